// File: rtl/logic_gate_controller.sv
// Debounced two-input logic gate for the Go Board: switches 1/2 are operands,
// switch 3 steps the gate mode, switch 4 clears it to AND, LED 4 flashes on every mode change.
`timescale 1ns/1ps
module logic_gate_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FLASH_CYCLES    = 6250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_t;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [1:0]    btn_q;
  logic [DW-1:0] db_cnt [4];
  logic          press_step;
  logic          press_clr;
  mode_t         state;
  mode_t         state_next;
  mode_t         state_q;
  logic          gate_next;
  logic [FW-1:0] flash_cnt;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A differing level must survive DEBOUNCE_CYCLES consecutive edges; any agreeing cycle restarts the count.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      deb   <= '0;
      btn_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_q <= deb[3:2];
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press_step = deb[2] & ~btn_q[0];
  assign press_clr  = deb[3] & ~btn_q[1];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= MODE_AND;
      state_q <= MODE_AND;
    end else begin
      state   <= state_next;
      state_q <= state;
    end
  end

  // Clear beats step when both presses land in the same cycle.
  always_comb begin
    state_next = state;
    if (press_clr) begin
      state_next = MODE_AND;
    end else if (press_step) begin
      unique case (state)
        MODE_AND:  state_next = MODE_OR;
        MODE_OR:   state_next = MODE_XOR;
        MODE_XOR:  state_next = MODE_NAND;
        MODE_NAND: state_next = MODE_AND;
        default:   state_next = MODE_AND;
      endcase
    end
  end

  always_comb begin
    gate_next = 1'b0;
    unique case (state)
      MODE_AND:  gate_next = deb[0] & deb[1];
      MODE_OR:   gate_next = deb[0] | deb[1];
      MODE_XOR:  gate_next = deb[0] ^ deb[1];
      MODE_NAND: gate_next = ~(deb[0] & deb[1]);
      default:   gate_next = 1'b0;
    endcase
  end

  assign o_LED_2 = state[1];
  assign o_LED_3 = state[0];

  // The flash keys off an actual register change, so a clear while already in AND stays dark.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_LED_1   <= 1'b0;
      flash_cnt <= '0;
    end else begin
      o_LED_1 <= gate_next;
      if (state != state_q) begin
        flash_cnt <= FLASH_LOAD;
      end else if (flash_cnt != '0) begin
        flash_cnt <= flash_cnt - FW'(1);
      end
    end
  end

  assign o_LED_4 = (flash_cnt != '0);

endmodule

// File: tb/tb_logic_gate_controller.sv
// Bench for logic_gate_controller: per-cycle expected LED vectors {led4, led2, led3, led1}
// are queued with their due cycle when stimulus is driven and compared at the falling edge.
`timescale 1ns/1ps
module tb_logic_gate_controller;

  localparam int DB = 4;
  localparam int FL = 8;
  localparam int W  = 24;

  logic clk = 1'b0;
  logic rst_n;
  logic sw1, sw2, sw3, sw4;
  logic led1, led2, led3, led4;
  logic [3:0] vec;

  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int k;
  logic [1:0] mode;
  logic cur_a, cur_b;

  logic_gate_controller #(
    .DEBOUNCE_CYCLES(DB),
    .FLASH_CYCLES(FL)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Switch_1(sw1),
    .i_Switch_2(sw2),
    .i_Switch_3(sw3),
    .i_Switch_4(sw4),
    .o_LED_1(led1),
    .o_LED_2(led2),
    .o_LED_3(led3),
    .o_LED_4(led4)
  );

  assign vec = {led4, led2, led3, led1};

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic push(input int due, input logic [3:0] val);
    exp_q.push_back({due[19:0], val});
  endtask

  function automatic logic gate_ref(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Scoreboard: compare every entry due after the edge just taken.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (int'(exp_q[i][23:4]) == cyc) begin
        check("leds", vec, exp_q[i][3:0]);
        exp_q.delete(i);
      end
    end
  end

  task automatic hold_zero(input int n);
    int k0;
    k0 = cyc + 1;
    for (int i = 0; i < n; i++) push(k0 + i, 4'b0000);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ops(input logic a, input logic b);
    int k0;
    logic ov, nv;
    k0 = cyc + 1;
    ov = gate_ref(mode, cur_a, cur_b);
    nv = gate_ref(mode, a, b);
    for (int i = 0; i < 10; i++) push(k0 + i, {1'b0, mode, (i < 6) ? ov : nv});
    sw1 = a;
    sw2 = b;
    cur_a = a;
    cur_b = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic press(input logic b3, input logic b4);
    int k0;
    logic [1:0] nm;
    logic chg, l1, f;
    logic [1:0] m;
    nm = b4 ? 2'b00 : (b3 ? mode + 2'b01 : mode);
    chg = (nm != mode);
    k0 = cyc + 1;
    for (int i = 0; i < 20; i++) begin
      m  = (i < 6) ? mode : nm;
      l1 = gate_ref((i < 7) ? mode : nm, cur_a, cur_b);
      f  = chg && (i >= 7) && (i <= 14);
      push(k0 + i, {f, m, l1});
    end
    sw3 = b3;
    sw4 = b4;
    repeat (8) @(negedge clk);
    sw3 = 1'b0;
    sw4 = 1'b0;
    repeat (12) @(negedge clk);
    mode = nm;
  endtask

  initial begin
    rst_n = 1'b0;
    {sw1, sw2, sw3, sw4} = 4'b0000;
    mode = 2'b00;
    cur_a = 1'b0;
    cur_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset: all switches high (simultaneous 3/4 keeps AND), then async assert mid-cycle.
    k = cyc + 1;
    for (int i = 0; i < 12; i++) push(k + i, {3'b000, (i >= 6)});
    {sw1, sw2, sw3, sw4} = 4'b1111;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1 check("rst_async", vec, 4'b0000);
    {sw1, sw2, sw3, sw4} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_zero(20);

    // Gate truth table in AND mode.
    drive_ops(1'b0, 1'b0);
    drive_ops(1'b0, 1'b1);
    drive_ops(1'b1, 1'b0);
    drive_ops(1'b1, 1'b1);

    // Bounce rejection on switch 1 with switch 2 high.
    drive_ops(1'b0, 1'b1);
    k = cyc + 1;
    for (int i = 0; i < 18; i++) push(k + i, {1'b0, mode, (i >= 14)});
    for (int j = 0; j < 4; j++) begin
      sw1 = (j % 2 == 0);
      repeat (2) @(negedge clk);
    end
    sw1 = 1'b1;
    cur_a = 1'b1;
    repeat (10) @(negedge clk);

    // Mode cycle with both operands high.
    drive_ops(1'b1, 1'b1);
    for (int j = 0; j < 5; j++) press(1'b1, 1'b0);

    // Priority and clear.
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    press(1'b0, 1'b1);

    // Retrigger: step at k+6, clear lands at k+10 while the first flash is running.
    k = cyc + 1;
    for (int i = 0; i < 24; i++) begin
      push(k + i, {(i >= 7) && (i <= 18),
                   ((i >= 6) && (i < 10)) ? 2'b01 : 2'b00,
                   gate_ref(((i >= 7) && (i < 11)) ? 2'b01 : 2'b00, cur_a, cur_b)});
    end
    sw3 = 1'b1;
    repeat (4) @(negedge clk);
    sw4 = 1'b1;
    repeat (4) @(negedge clk);
    sw3 = 1'b0;
    repeat (4) @(negedge clk);
    sw4 = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the middle of a flash.
    k = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      push(k + i, {(i >= 7), (i >= 6) ? 2'b01 : 2'b00,
                   gate_ref((i >= 7) ? 2'b01 : 2'b00, cur_a, cur_b)});
    end
    sw3 = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1 check("rst_flash", vec, 4'b0000);
    {sw1, sw2, sw3, sw4} = 4'b0000;
    mode = 2'b00;
    cur_a = 1'b0;
    cur_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_zero(10);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    check("sb_drain", (exp_q.size() == 0) ? 4'd0 : 4'd1, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
